// File: rtl/mux32_rr_arbiter_if.sv
// Handshake/bus bundle between the two producers, the arbiter and the downstream consumer.
// master = producer/consumer environment, slave = arbiter; lock0/lock1 exist only with MUX_ARB_LOCK_EN.
interface mux32_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic [WIDTH-1:0] in1;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] in2;
  logic             ack1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
`ifdef MUX_ARB_LOCK_EN
  logic             lock0;
  logic             lock1;

  modport master (
    output req0, in1, req1, in2, out_ready, lock0, lock1,
    input  ack0, ack1, out_valid, out_data, out_src
  );

  modport slave (
    input  req0, in1, req1, in2, out_ready, lock0, lock1,
    output ack0, ack1, out_valid, out_data, out_src
  );
`else
  modport master (
    output req0, in1, req1, in2, out_ready,
    input  ack0, ack1, out_valid, out_data, out_src
  );

  modport slave (
    input  req0, in1, req1, in2, out_ready,
    output ack0, ack1, out_valid, out_data, out_src
  );
`endif
endinterface

// File: rtl/mux32_rr_arbiter.sv
// Two-source round-robin arbiter over a shared 32-bit 2:1 mux into a one-entry valid/ready stage; 1 clock req->out_valid.
// Acks are combinational and fire only when the stage is empty or draining; optional burst lock under MUX_ARB_LOCK_EN.
module bit32_mux2to1 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        sel,
  output logic [31:0] out
);
  assign out = sel ? in2 : in1;
endmodule

module mux32_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mux32_rr_arbiter_if.slave bus
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             last_q,      last_d;

  logic             elig0, elig1;
  logic             winner;
  logic             cap;
  logic [31:0]      mux_out;

`ifdef MUX_ARB_LOCK_EN
  logic             lock_act_q, lock_act_d;
  logic             lock_own_q, lock_own_d;
  logic             winner_lock;
`endif

  bit32_mux2to1 u_mux (
    .in1 (bus.in1),
    .in2 (bus.in2),
    .sel (winner),
    .out (mux_out)
  );

  always_comb begin
    elig0 = bus.req0;
    elig1 = bus.req1;
`ifdef MUX_ARB_LOCK_EN
    // While locked, the non-owner is invisible to arbitration.
    if (lock_act_q) begin
      if (lock_own_q) elig0 = 1'b0;
      else            elig1 = 1'b0;
    end
`endif
    winner = (elig0 & elig1) ? ~last_q : elig1;
    cap    = (~out_valid_q | bus.out_ready) & (elig0 | elig1);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
`ifdef MUX_ARB_LOCK_EN
    winner_lock = winner ? bus.lock1 : bus.lock0;
    lock_act_d  = lock_act_q;
    lock_own_d  = lock_own_q;
`endif
    if (cap) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_src_d   = winner;
      last_d      = winner;
`ifdef MUX_ARB_LOCK_EN
      // A locked capture always comes from the owner, so this both sets and releases.
      lock_act_d  = winner_lock;
      lock_own_d  = winner;
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
`ifdef MUX_ARB_LOCK_EN
      lock_act_q  <= 1'b0;
      lock_own_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
`ifdef MUX_ARB_LOCK_EN
      lock_act_q  <= lock_act_d;
      lock_own_q  <= lock_own_d;
`endif
    end
  end

  // Gate with rst_n so acks are low during reset even if requests and ready are high.
  assign bus.ack0      = rst_n & cap & ~winner;
  assign bus.ack1      = rst_n & cap &  winner;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed bench for mux32_rr_arbiter: reset, single grant, stall/release, alternation, async reset, optional lock.
module tb_mux32_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  mux32_rr_arbiter_if bus ();

  mux32_rr_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set: checks acks before
  // the rising edge, then the registered stage just after it.
  task automatic cyc(input string tag, input logic a0, input logic a1, input logic v,
                     input logic [31:0] d, input logic s);
    #4;
    chk({tag, "_ack0"}, 32'(bus.ack0), 32'(a0));
    chk({tag, "_ack1"}, 32'(bus.ack1), 32'(a1));
    chk({tag, "_excl"}, 32'(bus.ack0 & bus.ack1), 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_dat"}, bus.out_data, d);
    chk({tag, "_src"}, 32'(bus.out_src), 32'(s));
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req0      = 1'b1;
    bus.in1       = 32'hAAAAAAAA;
    bus.req1      = 1'b0;
    bus.in2       = 32'h55555555;
    bus.out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    bus.lock0     = 1'b0;
    bus.lock1     = 1'b0;
`endif
    #1;
    chk("rst_vld",  32'(bus.out_valid), 32'h0);
    chk("rst_dat",  bus.out_data, 32'h0);
    chk("rst_src",  32'(bus.out_src), 32'h0);
    chk("rst_ack0", 32'(bus.ack0), 32'h0);
    chk("rst_ack1", 32'(bus.ack1), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc("single", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);

    bus.req0 = 1'b0;
    cyc("drain", 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0);

    bus.req0      = 1'b1;
    bus.in1       = 32'h11111111;
    bus.out_ready = 1'b0;
    cyc("fill", 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0);

    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    repeat (5) cyc("stall", 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);

    bus.out_ready = 1'b1;
    cyc("release", 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1);

    bus.req1 = 1'b0;
    cyc("drain2", 1'b0, 1'b0, 1'b0, 32'h55555555, 1'b1);

    // last=1 here, so the tie goes to requester 0 first.
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.in1  = 32'hAAAAAAAA;
    cyc("rr0", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    cyc("rr1", 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1);
    cyc("rr2", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    cyc("rr3", 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1);

    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  32'(bus.out_valid), 32'h0);
    chk("arst_dat",  bus.out_data, 32'h0);
    chk("arst_src",  32'(bus.out_src), 32'h0);
    chk("arst_ack0", 32'(bus.ack0), 32'h0);
    chk("arst_ack1", 32'(bus.ack1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst0", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    cyc("post_rst1", 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1);

`ifdef MUX_ARB_LOCK_EN
    bus.lock0 = 1'b1;
    repeat (3) cyc("lock", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    bus.lock0 = 1'b0;
    cyc("unlock", 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    cyc("after_unlock", 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
